float_copro_seq: RTL

FLOAT_COPRO_SEQ -- requirements
Module: float_copro_seq

---
 rtl/float_copro_seq_pkg.sv | 61 ++++++
 rtl/float_copro_seq_if.sv | 15 +
 rtl/float_copro_seq_status.sv | 40 ++++
 rtl/float_copro_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/float_copro_seq_pkg.sv
// Shared types, opcodes, status-word layout and IEEE <-> internal float
// conversion for the float coprocessor sequencer.
package float_pack;

  // Internal format keeps the IEEE exponent bias, so NE stays at 8.
  localparam int NE = 8;
  localparam int NM = 16;
  localparam int FW = NE + NM + 1;

  typedef struct packed {
    logic          sign;
    logic [NE-1:0] exp;
    logic [NM-1:0] man;
  } float_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_STAT = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  localparam logic [NE-1:0] EXP_SAT = {{(NE-1){1'b1}}, 1'b0};

  function automatic logic [31:0] pack_status(input logic illegal, input logic dropped,
                                              input logic divz, input logic ovf,
                                              input logic [15:0] count);
    return {illegal, dropped, divz, ovf, 12'b0, count};
  endfunction

  // Denormals flush to signed zero, Inf/NaN saturate to the largest finite value.
  function automatic float_t ieee_to_float(input logic [31:0] v);
    float_t f;
    logic   unused_lsbs;
    unused_lsbs = ^v[22-NM:0];
    f.sign = v[31];
    if (v[30:23] == 8'h00) begin
      f.exp = '0;
      f.man = '0;
    end else if (v[30:23] == 8'hFF) begin
      f.exp = EXP_SAT;
      f.man = '1;
    end else begin
      f.exp = v[30:23];
      f.man = v[22 -: NM];
    end
    return f;
  endfunction

  function automatic logic [31:0] float_to_ieee(input float_t f);
    if (f.exp == '1) return {f.sign, 8'hFE, 23'h7FFFFF};
    return {f.sign, f.exp, f.man, {(23-NM){1'b0}}};
  endfunction

  function automatic logic is_sat(input float_t f);
    return (f.exp == '1) || ((f.exp == EXP_SAT) && (f.man == '1));
  endfunction

endpackage

// File: rtl/float_copro_seq_if.sv
// CPU-side request/response bundle of the float coprocessor sequencer.
interface float_copro_seq_if;
  logic        start_i;
  logic [2:0]  opcode_i;
  logic [31:0] dataa_i;
  logic [31:0] datab_i;
  logic        done_o;
  logic [31:0] result_o;
  logic        busy_o;

  modport master (output start_i, opcode_i, dataa_i, datab_i,
                  input  done_o, result_o, busy_o);
  modport slave  (input  start_i, opcode_i, dataa_i, datab_i,
                  output done_o, result_o, busy_o);
endinterface

// File: rtl/float_copro_seq_status.sv
// Sticky status flags plus the arithmetic completion counter; a clear
// overrides any set or count step landing in the same cycle.
module float_copro_seq_status
  import float_pack::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_illegal_i,
  input  logic        set_dropped_i,
  input  logic        set_divz_i,
  input  logic        set_ovf_i,
  input  logic        clear_i,
  input  logic        count_i,
  output logic [31:0] status_o
);
  logic [3:0]  flags_q, flags_d;
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    flags_d    = flags_q | {set_illegal_i, set_dropped_i, set_divz_i, set_ovf_i};
    op_count_d = op_count_q + {15'b0, count_i};
    if (clear_i) begin
      flags_d    = '0;
      op_count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q    <= '0;
      op_count_q <= '0;
    end else begin
      flags_q    <= flags_d;
      op_count_q <= op_count_d;
    end
  end

  assign status_o = pack_status(flags_q[3], flags_q[2], flags_q[1], flags_q[0], op_count_q);

endmodule

// File: rtl/float_copro_seq.sv
// Sequencer between a CPU strobe interface and an external float datapath:
// converts operands, issues one operation at a time and tracks sticky status.
module float_copro_seq
  import float_pack::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  float_copro_seq_if.slave bus,
  output logic [1:0]       dp_op_o,
  output logic [FW-1:0]    dp_a_o,
  output logic [FW-1:0]    dp_b_o,
  output logic             dp_valid_o,
  input  logic [FW-1:0]    dp_result_i
);
  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
  localparam int CNT_W   = (LAT_MAX > 2) ? $clog2(LAT_MAX) : 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  float_t          a_q, a_d, b_q, b_d, a_conv, b_conv;
  logic [31:0]     result_q, result_d, status;
  logic            arith_q, arith_d;
  logic            set_illegal, set_dropped, set_divz, set_ovf, clr_stat, count_inc;

  function automatic logic [CNT_W-1:0] lat_load(input logic [1:0] op);
    case (op)
      2'd2:    return CNT_W'(LAT_MUL - 1);
      2'd3:    return CNT_W'(LAT_DIV - 1);
      default: return CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  assign a_conv = ieee_to_float(bus.dataa_i);
  assign b_conv = ieee_to_float(bus.datab_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    arith_d     = arith_q;
    set_illegal = 1'b0;
    set_dropped = bus.start_i && (state_q != ST_IDLE);
    set_divz    = 1'b0;
    set_ovf     = 1'b0;
    clr_stat    = 1'b0;
    count_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_DONE;
          arith_d = !bus.opcode_i[2];
          if (!bus.opcode_i[2]) begin
            state_d  = ST_ISSUE;
            op_d     = bus.opcode_i[1:0];
            a_d      = a_conv;
            b_d      = b_conv;
            set_divz = (bus.opcode_i == OP_DIV) && (b_conv.exp == '0) && (b_conv.man == '0);
          end else if (bus.opcode_i == OP_STAT) begin
            result_d = status;
          end else if (bus.opcode_i == OP_CLR) begin
            result_d = '0;
            clr_stat = 1'b1;
          end else begin
            result_d    = '0;
            set_illegal = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = lat_load(op_q);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          result_d = float_to_ieee(dp_result_i);
          set_ovf  = is_sat(dp_result_i);
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        count_inc = arith_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      arith_q  <= arith_d;
    end
  end

  float_copro_seq_status u_status (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_illegal_i (set_illegal),
    .set_dropped_i (set_dropped),
    .set_divz_i    (set_divz),
    .set_ovf_i     (set_ovf),
    .clear_i       (clr_stat),
    .count_i       (count_inc),
    .status_o      (status)
  );

  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.result_o = result_q;
  assign dp_valid_o   = (state_q == ST_ISSUE);
  assign dp_op_o      = op_q;
  assign dp_a_o       = a_q;
  assign dp_b_o       = b_q;

endmodule
